// File: rtl/router_port_sink_if.sv
// Router output port to packet sink bundle: FIFO read handshake, payload stream,
// packet status pulses and statistics counters.
interface router_port_sink_if;
  logic        vld_out;
  logic [7:0]  data_out;
  logic        sink_ready;
  logic        read_enb;
  logic [7:0]  byte_out;
  logic        byte_vld;
  logic [1:0]  pkt_addr;
  logic [5:0]  pkt_len;
  logic        pkt_done;
  logic        parity_err;
  logic        addr_err;
  logic        timeout_err;
  logic        busy;
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  modport master (
    output vld_out, data_out, sink_ready,
    input  read_enb, byte_out, byte_vld, pkt_addr, pkt_len, pkt_done,
           parity_err, addr_err, timeout_err, busy, pkt_count, err_count
  );

  modport slave (
    input  vld_out, data_out, sink_ready,
    output read_enb, byte_out, byte_vld, pkt_addr, pkt_len, pkt_done,
           parity_err, addr_err, timeout_err, busy, pkt_count, err_count
  );
endinterface

// File: rtl/router_port_sink.sv
// Drains one router output port: reads header, payload and parity from the port FIFO,
// streams payload bytes, reports packet status/errors and keeps saturating statistics.
module router_port_sink #(
  parameter logic [1:0]  PORT_ID = 2'd0,
  parameter int unsigned TIMEOUT = 32
) (
  input logic             clock,
  input logic             reset,
  router_port_sink_if.slave port
);

  typedef enum logic [1:0] {IDLE, HDR_WAIT, BODY, DONE} state_t;

  localparam logic [7:0] IdleLimit = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        rdPend_q, rdPend_d;
  logic [5:0]  len_q, len_d;
  logic [1:0]  addr_q, addr_d;
  logic [6:0]  remReq_q, remReq_d;
  logic [6:0]  rxCnt_q, rxCnt_d;
  logic [7:0]  parity_q, parity_d;
  logic        parErr_q, parErr_d;
  logic [7:0]  idle_q, idle_d;
  logic [7:0]  byteOut_q, byteOut_d;
  logic        byteVld_q, byteVld_d;
  logic [1:0]  pktAddr_q, pktAddr_d;
  logic [5:0]  pktLen_q, pktLen_d;
  logic [15:0] pktCnt_q, pktCnt_d;
  logic [15:0] errCnt_q, errCnt_d;

  logic arrive, inPkt, hdrArrive, payArrive, parArrive, tmoHit, addrBad, readEn;

  // A read sampled last cycle means data_out carries a byte this cycle.
  assign arrive    = rdPend_q;
  assign inPkt     = (state_q == HDR_WAIT) || (state_q == BODY);
  assign hdrArrive = (state_q == HDR_WAIT) && arrive;
  assign payArrive = (state_q == BODY) && arrive && (rxCnt_q < {1'b0, len_q});
  assign parArrive = (state_q == BODY) && arrive && (rxCnt_q == {1'b0, len_q});
  assign tmoHit    = inPkt && !arrive && port.sink_ready && (idle_q == IdleLimit);
  assign addrBad   = addr_q != PORT_ID;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (port.vld_out) state_d = HDR_WAIT;
      HDR_WAIT: if (hdrArrive) state_d = BODY;
                else if (tmoHit) state_d = IDLE;
      BODY:     if (tmoHit) state_d = IDLE;
                else if (parArrive) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    readEn = 1'b0;
    if (!reset) begin
      if (state_q == IDLE)
        readEn = port.vld_out;
      else if (state_q == BODY)
        readEn = port.vld_out && port.sink_ready && (remReq_q != 7'd0) && !tmoHit;
    end
    port.read_enb    = readEn;
    port.busy        = state_q != IDLE;
    port.pkt_done    = state_q == DONE;
    port.parity_err  = (state_q == DONE) && parErr_q;
    port.addr_err    = (state_q == DONE) && addrBad;
    port.timeout_err = tmoHit;
    port.byte_out    = byteOut_q;
    port.byte_vld    = byteVld_q;
    port.pkt_addr    = pktAddr_q;
    port.pkt_len     = pktLen_q;
    port.pkt_count   = pktCnt_q;
    port.err_count   = errCnt_q;
  end

  always_comb begin
    rdPend_d  = readEn;
    len_d     = len_q;
    addr_d    = addr_q;
    remReq_d  = remReq_q;
    rxCnt_d   = rxCnt_q;
    parity_d  = parity_q;
    parErr_d  = parErr_q;
    idle_d    = 8'd0;
    byteOut_d = byteOut_q;
    byteVld_d = 1'b0;
    pktAddr_d = pktAddr_q;
    pktLen_d  = pktLen_q;
    pktCnt_d  = pktCnt_q;
    errCnt_d  = errCnt_q;

    if (hdrArrive) begin
      len_d    = port.data_out[7:2];
      addr_d   = port.data_out[1:0];
      remReq_d = {1'b0, port.data_out[7:2]} + 7'd1;
      rxCnt_d  = 7'd0;
      parity_d = port.data_out;
      parErr_d = 1'b0;
    end
    if ((state_q == BODY) && readEn) remReq_d = remReq_q - 7'd1;
    if ((state_q == BODY) && arrive) rxCnt_d = rxCnt_q + 7'd1;
    if (payArrive) begin
      parity_d  = parity_q ^ port.data_out;
      byteOut_d = port.data_out;
      byteVld_d = 1'b1;
    end
    // Header fields are published together with the completion pulse.
    if (parArrive) begin
      parErr_d  = parity_q != port.data_out;
      pktAddr_d = addr_q;
      pktLen_d  = len_q;
    end
    if (inPkt && !arrive) idle_d = port.sink_ready ? idle_q + 8'd1 : idle_q;

    if (state_q == DONE) begin
      if (pktCnt_q != 16'hFFFF) pktCnt_d = pktCnt_q + 16'd1;
      if ((parErr_q || addrBad) && (errCnt_q != 16'hFFFF)) errCnt_d = errCnt_q + 16'd1;
    end
    if (tmoHit && (errCnt_q != 16'hFFFF)) errCnt_d = errCnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdPend_q  <= 1'b0;
      len_q     <= 6'd0;
      addr_q    <= 2'd0;
      remReq_q  <= 7'd0;
      rxCnt_q   <= 7'd0;
      parity_q  <= 8'd0;
      parErr_q  <= 1'b0;
      idle_q    <= 8'd0;
      byteOut_q <= 8'd0;
      byteVld_q <= 1'b0;
      pktAddr_q <= 2'd0;
      pktLen_q  <= 6'd0;
      pktCnt_q  <= 16'd0;
      errCnt_q  <= 16'd0;
    end else begin
      rdPend_q  <= rdPend_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      remReq_q  <= remReq_d;
      rxCnt_q   <= rxCnt_d;
      parity_q  <= parity_d;
      parErr_q  <= parErr_d;
      idle_q    <= idle_d;
      byteOut_q <= byteOut_d;
      byteVld_q <= byteVld_d;
      pktAddr_q <= pktAddr_d;
      pktLen_q  <= pktLen_d;
      pktCnt_q  <= pktCnt_d;
      errCnt_q  <= errCnt_d;
    end
  end

endmodule

// File: tb/tb_router_port_sink.sv
// Randomised packet bench: a queue-based router FIFO feeds the sink, and a packet-level
// model predicts the payload stream, completion/error events, counters and timing.
module tb_router_port_sink;
  localparam logic [1:0] PORT_ID = 2'd0;
  localparam int TIMEOUT = 32;

  typedef struct {
    bit         isTmo;
    logic [1:0] addr;
    logic [5:0] len;
    bit         parErr;
    bit         addrErr;
    int         nBytes;
  } evt_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  router_port_sink_if bus();

  router_port_sink #(.PORT_ID(PORT_ID), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock),
    .reset(reset),
    .port (bus)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] fifo[$];
  logic [7:0] expBytes[$];
  logic [7:0] lastPay[$];
  evt_t expEvt[$];
  bit presenting = 1'b0;
  bit rdSeen = 1'b0;
  int srMode = 0;
  int cyc = 0;
  bit pktActive = 1'b0;
  bit stalled = 1'b0;
  int idleModel = 0;
  int hdrCycle = 0;
  int bytesSeen = 0;
  int totalBytes = 0;
  int modelPkt = 0;
  int modelErr = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Queue one packet into the router FIFO; nPay < len leaves it truncated (no parity byte).
  task automatic applyStimulus(input logic [7:0] hdr, input int nPay, input logic [7:0] parXor, input bit reuse);
    logic [7:0] par;
    evt_t e;
    int len;
    len = int'(hdr[7:2]);
    if (!reuse) begin
      lastPay.delete();
      for (int i = 0; i < len; i++) lastPay.push_back(8'($urandom));
    end
    par = hdr;
    for (int i = 0; i < len; i++) par = par ^ lastPay[i];
    fifo.push_back(hdr);
    for (int i = 0; i < nPay; i++) begin
      fifo.push_back(lastPay[i]);
      expBytes.push_back(lastPay[i]);
    end
    e.isTmo   = nPay < len;
    e.addr    = hdr[1:0];
    e.len     = hdr[7:2];
    e.parErr  = parXor != 8'h00;
    e.addrErr = hdr[1:0] != PORT_ID;
    e.nBytes  = nPay;
    if (!e.isTmo) fifo.push_back(par ^ parXor);
    expEvt.push_back(e);
  endtask

  task automatic doReset();
    @(posedge clock); #1;
    reset = 1'b1;
    fifo.delete();
    expBytes.delete();
    expEvt.delete();
    bus.vld_out = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_read_enb", 32'(bus.read_enb), 0);
    checkOutput("rst_byte_vld", 32'(bus.byte_vld), 0);
    checkOutput("rst_byte_out", 32'(bus.byte_out), 0);
    checkOutput("rst_pkt_done", 32'(bus.pkt_done), 0);
    checkOutput("rst_parity_err", 32'(bus.parity_err), 0);
    checkOutput("rst_addr_err", 32'(bus.addr_err), 0);
    checkOutput("rst_timeout_err", 32'(bus.timeout_err), 0);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_pkt_addr", 32'(bus.pkt_addr), 0);
    checkOutput("rst_pkt_len", 32'(bus.pkt_len), 0);
    checkOutput("rst_pkt_count", 32'(bus.pkt_count), 0);
    checkOutput("rst_err_count", 32'(bus.err_count), 0);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((fifo.size() > 0 || expEvt.size() > 0 || pktActive) && n < 3000) begin
      @(posedge clock);
      n++;
    end
    if (n >= 3000) checkOutput("wait_idle_budget", 1, 0);
    @(negedge clock);
  endtask

  // Router port FIFO: data appears the cycle after a sampled read.
  initial begin : router
    bus.vld_out = 1'b0;
    bus.data_out = 8'h00;
    bus.sink_ready = 1'b1;
    forever begin
      @(negedge clock);
      rdSeen = bus.read_enb;
      @(posedge clock); #1;
      if (rdSeen && fifo.size() > 0) begin
        bus.data_out = fifo.pop_front();
        presenting = 1'b1;
      end else begin
        bus.data_out = 8'($urandom);
        presenting = 1'b0;
      end
      bus.vld_out = fifo.size() > 0;
      case (srMode)
        1:       bus.sink_ready = ((cyc / 3) % 2) == 0;
        2:       bus.sink_ready = $urandom_range(3) != 0;
        default: bus.sink_ready = 1'b1;
      endcase
    end
  end

  initial begin : compare
    evt_t ev;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        pktActive = 1'b0;
        idleModel = 0;
        bytesSeen = 0;
        totalBytes = 0;
        modelPkt = 0;
        modelErr = 0;
      end else begin
        checkOutput("pkt_count", 32'(bus.pkt_count), modelPkt);
        checkOutput("err_count", 32'(bus.err_count), modelErr);
        checkOutput("busy", 32'(bus.busy), 32'(pktActive));
        checkOutput("read_without_vld", 32'(bus.read_enb & ~bus.vld_out), 0);
        if (pktActive) begin
          if (presenting) idleModel = 0;
          else if (bus.sink_ready) idleModel++;
          if (!bus.sink_ready) stalled = 1'b1;
        end
        checkOutput("timeout_err", 32'(bus.timeout_err), 32'(pktActive && idleModel >= TIMEOUT));
        if (bus.byte_vld) begin
          if (expBytes.size() == 0) checkOutput("spurious_byte", 1, 0);
          else checkOutput("byte_out", 32'(bus.byte_out), 32'(expBytes.pop_front()));
          bytesSeen++;
          totalBytes++;
        end
        if (bus.pkt_done || bus.timeout_err) begin
          if (expEvt.size() == 0) checkOutput("spurious_event", 1, 0);
          else begin
            ev = expEvt.pop_front();
            checkOutput("event_kind", 32'(bus.timeout_err), 32'(ev.isTmo));
            checkOutput("event_bytes", bytesSeen, ev.nBytes);
            if (bus.pkt_done) begin
              checkOutput("pkt_addr", 32'(bus.pkt_addr), 32'(ev.addr));
              checkOutput("pkt_len", 32'(bus.pkt_len), 32'(ev.len));
              checkOutput("parity_err", 32'(bus.parity_err), 32'(ev.parErr));
              checkOutput("addr_err", 32'(bus.addr_err), 32'(ev.addrErr));
              if (!stalled) checkOutput("latency", cyc - hdrCycle, 32'(ev.len) + 4);
              if (modelPkt < 65535) modelPkt++;
              if ((ev.parErr || ev.addrErr) && modelErr < 65535) modelErr++;
            end else if (modelErr < 65535) modelErr++;
          end
          pktActive = 1'b0;
        end else if (bus.parity_err || bus.addr_err) begin
          checkOutput("error_without_done", 1, 0);
        end
        if (bus.read_enb && !pktActive) begin
          pktActive = 1'b1;
          hdrCycle = cyc;
          stalled = 1'b0;
          idleModel = 0;
          bytesSeen = 0;
        end
      end
    end
  end

  initial begin : main
    logic [7:0] hdr;
    logic [7:0] parXor;
    int n;
    int len;
    int nPay;

    doReset();

    applyStimulus(8'h38, 14, 8'h00, 1'b0);
    waitIdle();
    checkOutput("good_pkt_count", 32'(bus.pkt_count), 1);
    checkOutput("good_err_count", 32'(bus.err_count), 0);
    checkOutput("good_pkt_len", 32'(bus.pkt_len), 14);
    checkOutput("good_pkt_addr", 32'(bus.pkt_addr), 0);
    checkOutput("good_bytes", totalBytes, 14);

    doReset();
    applyStimulus(8'h38, 14, 8'h01, 1'b1);
    waitIdle();
    checkOutput("par_pkt_count", 32'(bus.pkt_count), 1);
    checkOutput("par_err_count", 32'(bus.err_count), 1);

    doReset();
    applyStimulus(8'h06, 1, 8'h00, 1'b0);
    waitIdle();
    checkOutput("addr_pkt_count", 32'(bus.pkt_count), 1);
    checkOutput("addr_err_count", 32'(bus.err_count), 1);
    checkOutput("addr_pkt_addr", 32'(bus.pkt_addr), 2);
    checkOutput("addr_pkt_len", 32'(bus.pkt_len), 1);
    checkOutput("addr_bytes", totalBytes, 1);

    applyStimulus(8'h00, 0, 8'h00, 1'b0);
    waitIdle();
    checkOutput("empty_pkt_count", 32'(bus.pkt_count), 2);
    checkOutput("empty_err_count", 32'(bus.err_count), 1);
    checkOutput("empty_pkt_len", 32'(bus.pkt_len), 0);
    checkOutput("empty_bytes", totalBytes, 1);

    applyStimulus(8'h38, 5, 8'h00, 1'b0);
    waitIdle();
    checkOutput("tmo_pkt_count", 32'(bus.pkt_count), 2);
    checkOutput("tmo_err_count", 32'(bus.err_count), 2);
    checkOutput("tmo_bytes", totalBytes, 6);
    checkOutput("tmo_busy", 32'(bus.busy), 0);

    for (int g = 0; g < 20; g++) begin
      n = $urandom_range(2, 1);
      srMode = $urandom_range(2);
      for (int k = 0; k < n; k++) begin
        hdr = {6'($urandom_range(24)), 2'($urandom_range(3))};
        len = int'(hdr[7:2]);
        nPay = len;
        if (k == n - 1 && len > 0 && $urandom_range(7) == 0) nPay = int'($urandom_range(len - 1));
        parXor = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
        applyStimulus(hdr, nPay, parXor, 1'b0);
      end
      waitIdle();
    end

    doReset();
    srMode = 1;
    applyStimulus({6'd20, 2'd0}, 20, 8'h00, 1'b0);
    waitIdle();
    checkOutput("stall_pkt_count", 32'(bus.pkt_count), 1);
    checkOutput("stall_bytes", totalBytes, 20);
    applyStimulus({6'd20, 2'd0}, 20, 8'h00, 1'b1);
    repeat (15) @(posedge clock);
    doReset();
    srMode = 0;
    applyStimulus(8'h0C, 3, 8'h00, 1'b0);
    waitIdle();
    checkOutput("post_rst_pkt_count", 32'(bus.pkt_count), 1);
    checkOutput("post_rst_err_count", 32'(bus.err_count), 0);
    checkOutput("post_rst_bytes", totalBytes, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_port_sink.md
ROUTER_PORT_SINK -- requirements
Module: router_port_sink

Interface
REQ-001 Parameter: PORT_ID, 2'd0, router output port this sink drains; compared with header addr.
REQ-002 Parameter: TIMEOUT, 32, max idle cycles between bytes inside a packet before abort (range 2..255).
REQ-003 clock  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 vld_out  input  1  router port FIFO non-empty.
REQ-006 data_out  input  8  router port FIFO read data, valid exactly 1 cycle after a sampled read_enb.
REQ-007 sink_ready  input  1  downstream can accept payload bytes; low stalls reads.
REQ-008 read_enb  output  1  FIFO read request to router port.
REQ-009 byte_out  output  8  payload byte (header and parity excluded).
REQ-010 byte_vld  output  1  byte_out valid, 1-cycle pulse per payload byte.
REQ-011 pkt_addr, pkt_len  output  2, 6  header fields of last finished packet, updated with pkt_done.
REQ-012 pkt_done  output  1  1-cycle pulse after parity byte received.
REQ-013 parity_err, addr_err, timeout_err  output  1 each  1-cycle error pulses.
REQ-014 busy  output  1  high whenever state != IDLE.
REQ-015 pkt_count, err_count  output  16 each  saturating counters.

Function
REQ-016 Packet format SHALL be: header {len[7:2], addr[1:0]}, len payload bytes, one parity byte; total bytes = len+2; len 0 is legal (header, parity only).
REQ-017 FSM states SHALL be IDLE, HDR_WAIT, BODY, DONE.
REQ-018 IDLE: when vld_out=1 assert read_enb for one cycle, go HDR_WAIT; header latched from data_out next cycle.
REQ-019 HDR_WAIT: on header arrival latch len/addr, set remaining-request count = len+1, go BODY; no read_enb in the header-arrival cycle (1-cycle bubble).
REQ-020 BODY: read_enb SHALL be asserted in any cycle where vld_out=1, sink_ready=1 and remaining-request count > 0; back-to-back reads allowed; count decrements per issued read.
REQ-021 read_enb SHALL never be asserted while vld_out=0, in HDR_WAIT header-arrival cycle, or in DONE.
REQ-022 Each returned byte SHALL be classified by received-byte counter: bytes 1..len -> byte_out/byte_vld same cycle as capture registered (1 cycle after arrival); byte len+1 -> parity.
REQ-023 Running parity SHALL be XOR of header and all payload bytes; mismatch with parity byte -> parity_err.
REQ-024 On parity byte arrival go DONE; DONE lasts 1 cycle, pulses pkt_done with pkt_addr/pkt_len, then IDLE.
REQ-025 addr_err SHALL pulse with pkt_done when header addr != PORT_ID; packet still fully drained.
REQ-026 pkt_count +1 per pkt_done; err_count +1 per packet with any of parity_err/addr_err/timeout_err (max +1 per packet); both saturate at 16'hFFFF.
REQ-027 Idle counter in HDR_WAIT/BODY SHALL reset on each received byte; reaching TIMEOUT -> timeout_err pulse, discard packet (no pkt_done, no pkt_count), go IDLE next cycle.
REQ-028 sink_ready low mid-packet SHALL stall reads without data loss; stall cycles count toward timeout only while sink_ready=1.
REQ-029 Minimum packet latency: pkt_done = header read cycle + len+4 cycles with vld_out and sink_ready held high.

Reset
REQ-030 reset=1 at any edge, including mid-packet: state IDLE, read_enb=0, byte_vld=0, all pulses 0, byte_out=0, pkt_addr=0, pkt_len=0, pkt_count=0, err_count=0, parity/counters cleared; partial packet discarded.
REQ-031 First read_enb SHALL occur no earlier than the first edge after reset deasserts with vld_out=1.

Verification
REQ-032 Header 8'h38 (len 14, addr 0), 14 random bytes, correct parity, PORT_ID 0 -> 14 byte_vld pulses in order, pkt_done, pkt_len=14, pkt_count=1, no errors.
REQ-033 Same packet with parity byte bit 0 flipped -> pkt_done with parity_err=1, err_count=1, pkt_count=1.
REQ-034 Header 8'h06 (len 1, addr 2), PORT_ID 0 -> addr_err with pkt_done, one byte_vld, err_count=1.
REQ-035 Header 8'h00 then parity 8'h00 -> pkt_done, pkt_len=0, zero byte_vld, no errors.
REQ-036 vld_out drops after 5 payload bytes of len 14, TIMEOUT=32 -> timeout_err 32 cycles after last byte, no pkt_done, busy low next cycle.
REQ-037 sink_ready toggled every 3 cycles during len 20 packet; reset pulsed mid-packet on second run -> first run byte stream intact; after reset all outputs at reset values.
